// File: rtl/ov_cam_capture_stream.sv
// ov_cam_capture_stream: OV-style DVP camera capture into a single-entry valid/ready pixel stream.
module ov_cam_capture_stream #(
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OUT_MODE = 0,
  localparam int OUT_W = (OUT_MODE == 1) ? 24 : 8 * BYTES_PER_PIX
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [7:0]       d_in,
  input  logic             vsync,
  input  logic             href,
  input  logic             en,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eol,
  output logic [15:0]      frame_cnt,
  output logic             line_err,
  output logic             frame_err,
  output logic             overflow,
  input  logic             err_clr
);
  localparam int PW = 8 * BYTES_PER_PIX;
  localparam logic [1:0] LAST_B = 2'(BYTES_PER_PIX - 1);
  localparam logic [15:0] H_W = 16'(H_ACTIVE);
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_W = 16'(V_ACTIVE);
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
  state_t state, state_nx;
  logic [7:0] d1;
  logic href1, vsync1, href_q;
  logic [1:0] bcnt;
  logic [PW-1:0] sh, word;
  logic [PW+7:0] cat;
  logic [OUT_W-1:0] pix;
  logic [15:0] pcnt, lcnt;
  logic cap, pix_done, emit, line_end, frame_end, ln_set, fr_set, ov_set;
  always_comb begin
    state_nx = (state == IDLE) ? (vsync1 ? SYNC : IDLE) :
               (state == SYNC) ? (vsync1 ? SYNC : (en ? ACTIVE : IDLE)) :
               (vsync1 ? SYNC : ACTIVE);
    cap = (state == ACTIVE) && href1;
    pix_done = cap && (bcnt == LAST_B);
    emit = pix_done && (pcnt < H_W);
    line_end = (state == ACTIVE) && href_q && !href1;
    frame_end = (state == ACTIVE) && vsync1;
    ln_set = (line_end && (pcnt != H_W)) || (frame_end && href1);
    fr_set = frame_end && (lcnt != V_W);
    ov_set = emit && m_valid && !m_ready;
    cat = {sh, d1};
    word = cat[PW-1:0];
  end
  // first byte lands in the top of the word, so the shift register is the MSB side
  if (OUT_MODE == 1) begin : g_rgb
    assign pix = {word[15:11], word[15:13], word[10:5], word[10:9], word[4:0], word[4:2]};
  end else begin : g_raw
    assign pix = word;
  end
  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= IDLE;
      d1 <= '0;
      href1 <= 1'b0;
      vsync1 <= 1'b0;
      href_q <= 1'b0;
      bcnt <= '0;
      sh <= '0;
      pcnt <= '0;
      lcnt <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_sof <= 1'b0;
      m_eol <= 1'b0;
      frame_cnt <= '0;
      line_err <= 1'b0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      d1 <= d_in;
      href1 <= href;
      vsync1 <= vsync;
      href_q <= href1;
      bcnt <= cap ? (pix_done ? 2'd0 : bcnt + 2'd1) : 2'd0;
      sh <= cap ? word : sh;
      if (state != ACTIVE) begin
        pcnt <= '0;
        lcnt <= '0;
      end else if (line_end) begin
        pcnt <= '0;
        lcnt <= lcnt + 16'd1;
      end else if (pix_done && pcnt != 16'hFFFF) begin
        pcnt <= pcnt + 16'd1;
      end
      if (emit && (!m_valid || m_ready)) begin
        m_data <= pix;
        m_valid <= 1'b1;
        m_sof <= (lcnt == 16'd0) && (pcnt == 16'd0);
        m_eol <= pcnt == H_LAST;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_sof <= 1'b0;
        m_eol <= 1'b0;
      end
      frame_cnt <= frame_end ? frame_cnt + 16'd1 : frame_cnt;
      line_err <= ln_set | (line_err & ~err_clr);
      frame_err <= fr_set | (frame_err & ~err_clr);
      overflow <= ov_set | (overflow & ~err_clr);
    end
  end
endmodule

// File: doc/ov_cam_capture_stream.md
OV_CAM_CAPTURE_STREAM -- requirements
Module: ov_cam_capture_stream

Interface
REQ-001 SHALL have parameter BYTES_PER_PIX, default 2, meaning camera bytes per pixel; legal values 1..3.
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning expected pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning expected lines per frame.
REQ-004 SHALL have parameter OUT_MODE, default 0, meaning 0 = raw byte pack, 1 = RGB565-to-RGB888 expand; mode 1 is legal only with BYTES_PER_PIX=2.
REQ-005 SHALL define OUT_W as 24 when OUT_MODE=1, else 8*BYTES_PER_PIX.
REQ-006 pclk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 d_in  input  8  camera data bus.
REQ-009 vsync  input  1  camera frame sync, high between frames.
REQ-010 href  input  1  camera line-valid.
REQ-011 en  input  1  capture enable, sampled only at frame start.
REQ-012 m_data  output  OUT_W  pixel data.
REQ-013 m_valid  output  1  pixel valid.
REQ-014 m_ready  input  1  downstream accept.
REQ-015 m_sof  output  1  first pixel of frame, qualified by m_valid.
REQ-016 m_eol  output  1  last pixel of line (index H_ACTIVE-1), qualified by m_valid.
REQ-017 frame_cnt  output  16  completed captured frames, wraps 0xFFFF->0.
REQ-018 line_err  output  1  sticky: line pixel count != H_ACTIVE.
REQ-019 frame_err  output  1  sticky: frame line count != V_ACTIVE.
REQ-020 overflow  output  1  sticky: pixel dropped because the output was held.
REQ-021 err_clr  input  1  clears the three sticky flags.

Function
REQ-022 d_in, href, vsync SHALL be registered once before use (stage 1).
REQ-023 FSM states: IDLE, SYNC, ACTIVE.
REQ-024 IDLE: stage-1 vsync=1 -> SYNC.
REQ-025 SYNC: stage-1 vsync=0 -> ACTIVE if en=1, else IDLE (frame skipped, no output, no counters).
REQ-026 ACTIVE: stage-1 vsync=1 -> SYNC; frame close per REQ-033.
REQ-027 Bytes SHALL be collected only while stage-1 href=1; byte counter 0..BYTES_PER_PIX-1, cleared at href rising edge; first byte is most significant.
REQ-028 On the last byte of a pixel, the pixel SHALL be presented: m_valid high 2 pclk after that byte is on d_in at a rising edge.
REQ-029 OUT_MODE=1 mapping: m_data = {R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}, where the word is {R5,G6,B5}.
REQ-030 m_valid SHALL stay high with m_data/m_sof/m_eol stable until m_valid&&m_ready; the output register is single-entry.
REQ-031 If a new pixel completes while m_valid=1 and m_ready=0, the new pixel SHALL be dropped and overflow set; the held pixel is kept.
REQ-032 Pixel index per line SHALL count 0..H_ACTIVE-1; pixels at index >= H_ACTIVE SHALL be dropped and line_err set at line end.
REQ-033 At href falling edge: if pixel count != H_ACTIVE, line_err SHALL be set; line count increments; a partial pixel SHALL be discarded without output.
REQ-034 Frame close, on stage-1 vsync rising in ACTIVE: frame_cnt+1; frame_err set if line count != V_ACTIVE; vsync rising mid-line also sets line_err.
REQ-035 m_sof SHALL accompany pixel 0 of line 0 only.
REQ-036 err_clr takes effect on the next edge; a simultaneous set wins over clear.

Reset
REQ-037 While reset=1: state IDLE; m_data=0, m_valid=0, m_sof=0, m_eol=0, frame_cnt=0, all sticky flags 0, all counters 0; effective mid-line, and the in-progress frame is not counted.

Verification
REQ-038 Defaults, 640x480 RGB565 frame, m_ready=1 -> 307200 m_valid pulses, 1 m_sof, 480 m_eol, frame_cnt=1, no flags.
REQ-039 OUT_MODE=1, bytes 0xF8,0x1F -> m_data=0xFF00FF, 2 pclk after the second byte.
REQ-040 Line of 639 pixels -> no m_eol on that line, line_err=1 after href fall; err_clr -> 0.
REQ-041 m_ready=0 across 2 pixel completions -> first pixel held, second dropped, overflow=1.
REQ-042 en=0 at frame start -> zero m_valid, frame_cnt unchanged.
REQ-043 reset asserted at pixel 100 of line 5, then a full frame -> frame_cnt=1, m_sof seen once.
